// File: rtl/mc_cu_if.sv
// mc_cu_if: control-unit bus between the multi-cycle control unit and its datapath.
// The master modport is the control unit and the slave modport is the datapath.
interface mc_cu_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             z;
    logic             mem_ready;
    logic             wpc;
    logic             wir;
    logic             iord;
    logic             wmem;
    logic             wreg;
    logic             regrt;
    logic             m2reg;
    logic             jal;
    logic             shift;
    logic             sext;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [3:0]       aluc;
    logic [1:0]       pcsource;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, func, z, mem_ready,
        output wpc, wir, iord, wmem, wreg, regrt, m2reg, jal, shift, sext,
               alusrca, alusrcb, aluc, pcsource, state, illegal, instret
    );

    modport slave (
        output op, func, z, mem_ready,
        input  wpc, wir, iord, wmem, wreg, regrt, m2reg, jal, shift, sext,
               alusrca, alusrcb, aluc, pcsource, state, illegal, instret
    );
endinterface

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle MIPS-subset control unit sequencing IF/ID/EXE/MEM/WB over a shared ALU and memory port.
// Optional feature: define MC_CU_HAMM_EN to decode R-type func 110010 as hamm (otherwise it is illegal).
module mc_cu #(
    parameter int CNT_W = 32
) (
    input logic     clock,
    input logic     reset,
    mc_cu_if.master bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t cur, nxt;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_hamm;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic legal, is_shift, is_imm, is_itype, is_branch, taken, dec_sext;
    logic [3:0] dec_aluc;

    logic wpc_c, wir_c, wmem_c, wreg_c, illegal_c, retire;

    assign r_type = bus.op == 6'b000000;
    assign i_add  = r_type & (bus.func == 6'b100000);
    assign i_sub  = r_type & (bus.func == 6'b100010);
    assign i_and  = r_type & (bus.func == 6'b100100);
    assign i_or   = r_type & (bus.func == 6'b100101);
    assign i_xor  = r_type & (bus.func == 6'b100110);
    assign i_sll  = r_type & (bus.func == 6'b000000);
    assign i_srl  = r_type & (bus.func == 6'b000010);
    assign i_sra  = r_type & (bus.func == 6'b000011);
    assign i_jr   = r_type & (bus.func == 6'b001000);
`ifdef MC_CU_HAMM_EN
    assign i_hamm = r_type & (bus.func == 6'b110010);
`else
    assign i_hamm = 1'b0;
`endif
    assign i_addi = bus.op == 6'b001000;
    assign i_andi = bus.op == 6'b001100;
    assign i_ori  = bus.op == 6'b001101;
    assign i_xori = bus.op == 6'b001110;
    assign i_lw   = bus.op == 6'b100011;
    assign i_sw   = bus.op == 6'b101011;
    assign i_beq  = bus.op == 6'b000100;
    assign i_bne  = bus.op == 6'b000101;
    assign i_lui  = bus.op == 6'b001111;
    assign i_j    = bus.op == 6'b000010;
    assign i_jal  = bus.op == 6'b000011;

    assign is_shift  = i_sll | i_srl | i_sra;
    assign is_branch = i_beq | i_bne;
    assign is_itype  = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw;
    assign is_imm    = is_itype | i_sw;
    assign legal     = i_add | i_sub | i_and | i_or | i_xor | is_shift | i_jr | i_hamm |
                       is_imm | is_branch | i_j | i_jal;
    assign taken     = (i_beq & bus.z) | (i_bne & ~bus.z);
    assign dec_sext  = i_addi | i_lw | i_sw | is_branch;
    assign dec_aluc  = {i_sra | i_hamm,
                        i_sub | i_or | i_srl | i_sra | i_ori | i_lui | is_branch,
                        i_xor | is_shift | i_xori | i_lui | i_hamm,
                        i_and | i_or | is_shift | i_andi | i_ori | i_hamm};

    // state register; asynchronous reset aborts any instruction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur <= S_IF;
        else       cur <= nxt;
    end

    // next-state and per-state control outputs, everything defaults to 0
    always_comb begin
        nxt          = cur;
        wpc_c        = 1'b0;
        wir_c        = 1'b0;
        wmem_c       = 1'b0;
        wreg_c       = 1'b0;
        illegal_c    = 1'b0;
        bus.iord     = 1'b0;
        bus.regrt    = 1'b0;
        bus.m2reg    = 1'b0;
        bus.jal      = 1'b0;
        bus.shift    = 1'b0;
        bus.sext     = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.aluc     = 4'b0000;
        bus.pcsource = 2'b00;
        case (cur)
            S_IF: begin
                bus.alusrcb = 2'b01;
                wir_c       = bus.mem_ready;
                wpc_c       = bus.mem_ready;
                nxt         = bus.mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                bus.alusrcb  = 2'b11;
                bus.sext     = 1'b1;
                wpc_c        = i_j | i_jal | i_jr;
                wreg_c       = i_jal;
                bus.jal      = i_jal;
                bus.pcsource = (i_j | i_jal) ? 2'b11 : i_jr ? 2'b10 : 2'b00;
                illegal_c    = ~legal;
                nxt          = (i_j | i_jal | i_jr | ~legal) ? S_IF : S_EXE;
            end
            S_EXE: begin
                bus.aluc     = dec_aluc;
                bus.sext     = dec_sext;
                bus.shift    = is_shift;
                bus.alusrca  = ~is_shift;
                bus.alusrcb  = is_imm ? 2'b10 : 2'b00;
                wpc_c        = taken;
                bus.pcsource = taken ? 2'b01 : 2'b00;
                nxt          = is_branch ? S_IF : (i_lw | i_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.iord = 1'b1;
                wmem_c   = i_sw;
                nxt      = bus.mem_ready ? (i_sw ? S_IF : S_WB) : S_MEM;
            end
            S_WB: begin
                wreg_c    = 1'b1;
                bus.m2reg = i_lw;
                bus.regrt = is_itype;
                nxt       = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end

    assign bus.wpc     = wpc_c & ~reset;
    assign bus.wir     = wir_c & ~reset;
    assign bus.wmem    = wmem_c & ~reset;
    assign bus.wreg    = wreg_c & ~reset;
    assign bus.illegal = illegal_c;
    assign bus.state   = cur;

    assign retire = (cur != S_IF) && (nxt == S_IF) && !illegal_c;

    // retired-instruction counter, bumped when a completing state hands back to IF
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       bus.instret <= '0;
        else if (retire) bus.instret <= bus.instret + 1'b1;
    end
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: scoreboard bench for mc_cu driven by a per-instruction phase-path reference model.
module tb_mc_cu;
    typedef enum int {K_R, K_SH, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_ILL} kind_e;
    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        kind_e      kind;
        logic [3:0] aluc;
        logic       sext;
        logic       bne;
    } ins_t;
    typedef struct packed {
        logic [2:0]  st;
        logic [19:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] cnt = 0;
    ins_t tab[23];
    exp_t q[$];
    exp_t me;

    mc_cu_if #(.CNT_W(32)) bus();
    mc_cu #(.CNT_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [19:0] ctl_of(input int ph, input ins_t t, input logic z, input logic mr);
        logic wpc = 0, wir = 0, iord = 0, wmem = 0, wreg = 0, regrt = 0, m2reg = 0;
        logic jal = 0, shift = 0, sext = 0, asa = 0, ill = 0;
        logic [1:0] asb = 0, pcs = 0;
        logic [3:0] aluc = 0;
        case (ph)
            0: begin
                asb = 2'b01;
                wir = mr;
                wpc = mr;
            end
            1: begin
                asb  = 2'b11;
                sext = 1'b1;
                wpc  = t.kind inside {K_J, K_JAL, K_JR};
                pcs  = (t.kind == K_JR) ? 2'b10 : (t.kind inside {K_J, K_JAL}) ? 2'b11 : 2'b00;
                wreg = t.kind == K_JAL;
                jal  = t.kind == K_JAL;
                ill  = t.kind == K_ILL;
            end
            2: begin
                aluc  = t.aluc;
                sext  = t.sext;
                shift = t.kind == K_SH;
                asa   = t.kind != K_SH;
                asb   = (t.kind inside {K_I, K_LW, K_SW}) ? 2'b10 : 2'b00;
                if (t.kind == K_BR && (t.bne ? !z : z)) begin
                    wpc = 1'b1;
                    pcs = 2'b01;
                end
            end
            3: begin
                iord = 1'b1;
                wmem = t.kind == K_SW;
            end
            default: begin
                wreg  = 1'b1;
                m2reg = t.kind == K_LW;
                regrt = t.kind inside {K_I, K_LW};
            end
        endcase
        return {wpc, wir, iord, wmem, wreg, regrt, m2reg, jal, shift, sext, asa, asb, aluc, pcs, ill};
    endfunction

    function automatic int plen(input kind_e k);
        case (k)
            K_J, K_JAL, K_JR, K_ILL: return 2;
            K_BR:                    return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    function automatic int pstep(input kind_e k, input int i);
        if (i < 3) return i;
        return (i == 3 && (k == K_LW || k == K_SW)) ? 3 : 4;
    endfunction

    task automatic run(input ins_t t, input bit rnd);
        int i = 0;
        int lows = 0;
        int ph;
        logic mr, z;
        bus.op   = t.op;
        bus.func = (t.op == 6'd0) ? t.func : 6'($urandom);
        while (i < plen(t.kind)) begin
            ph = pstep(t.kind, i);
            z  = 1'($urandom);
            mr = (!rnd || lows >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            lows = mr ? 0 : lows + 1;
            bus.z = z;
            bus.mem_ready = mr;
            q.push_back('{3'(ph), ctl_of(ph, t, z, mr), cnt});
            if (!((ph == 0 || ph == 3) && !mr)) i++;
            if (i == plen(t.kind) && t.kind != K_ILL) cnt++;
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            check("state", 32'(bus.state), 32'(me.st));
            check("ctl", 32'({bus.wpc, bus.wir, bus.iord, bus.wmem, bus.wreg, bus.regrt, bus.m2reg,
                              bus.jal, bus.shift, bus.sext, bus.alusrca, bus.alusrcb, bus.aluc,
                              bus.pcsource, bus.illegal}), 32'(me.ctl));
            check("instret", bus.instret, me.cnt);
        end
    end

    initial begin
        tab[0]  = '{6'b000000, 6'b100000, K_R,   4'b0000, 1'b0, 1'b0};
        tab[1]  = '{6'b000000, 6'b100010, K_R,   4'b0100, 1'b0, 1'b0};
        tab[2]  = '{6'b000000, 6'b100100, K_R,   4'b0001, 1'b0, 1'b0};
        tab[3]  = '{6'b000000, 6'b100101, K_R,   4'b0101, 1'b0, 1'b0};
        tab[4]  = '{6'b000000, 6'b100110, K_R,   4'b0010, 1'b0, 1'b0};
        tab[5]  = '{6'b000000, 6'b000000, K_SH,  4'b0011, 1'b0, 1'b0};
        tab[6]  = '{6'b000000, 6'b000010, K_SH,  4'b0111, 1'b0, 1'b0};
        tab[7]  = '{6'b000000, 6'b000011, K_SH,  4'b1111, 1'b0, 1'b0};
        tab[8]  = '{6'b000000, 6'b001000, K_JR,  4'b0000, 1'b0, 1'b0};
        tab[9]  = '{6'b001000, 6'b000000, K_I,   4'b0000, 1'b1, 1'b0};
        tab[10] = '{6'b001100, 6'b000000, K_I,   4'b0001, 1'b0, 1'b0};
        tab[11] = '{6'b001101, 6'b000000, K_I,   4'b0101, 1'b0, 1'b0};
        tab[12] = '{6'b001110, 6'b000000, K_I,   4'b0010, 1'b0, 1'b0};
        tab[13] = '{6'b001111, 6'b000000, K_I,   4'b0110, 1'b0, 1'b0};
        tab[14] = '{6'b100011, 6'b000000, K_LW,  4'b0000, 1'b1, 1'b0};
        tab[15] = '{6'b101011, 6'b000000, K_SW,  4'b0000, 1'b1, 1'b0};
        tab[16] = '{6'b000100, 6'b000000, K_BR,  4'b0100, 1'b1, 1'b0};
        tab[17] = '{6'b000101, 6'b000000, K_BR,  4'b0100, 1'b1, 1'b1};
        tab[18] = '{6'b000010, 6'b000000, K_J,   4'b0000, 1'b0, 1'b0};
        tab[19] = '{6'b000011, 6'b000000, K_JAL, 4'b0000, 1'b0, 1'b0};
        tab[20] = '{6'b111111, 6'b000000, K_ILL, 4'b0000, 1'b0, 1'b0};
        tab[21] = '{6'b000000, 6'b000001, K_ILL, 4'b0000, 1'b0, 1'b0};
`ifdef MC_CU_HAMM_EN
        tab[22] = '{6'b000000, 6'b110010, K_R,   4'b1011, 1'b0, 1'b0};
`else
        tab[22] = '{6'b000000, 6'b110010, K_ILL, 4'b0000, 1'b0, 1'b0};
`endif
        bus.op = 6'd0;
        bus.func = 6'd0;
        bus.z = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        check("rst_strobes", 32'({bus.wpc, bus.wir, bus.wmem, bus.wreg}), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        foreach (tab[k]) run(tab[k], 1'b0);
        repeat (150) run(tab[$urandom_range(0, 22)], 1'b1);
        bus.op = 6'b100011;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        bus.mem_ready = 1'b0;
        check("lw_mem_state", 32'(bus.state), 32'd3);
        check("lw_mem_iord", 32'(bus.iord), 32'd1);
        check("lw_mem_instret", bus.instret, cnt);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", 32'(bus.state), 32'd0);
        check("arst_instret", bus.instret, 32'd0);
        check("arst_strobes", 32'({bus.wpc, bus.wir, bus.wmem, bus.wreg}), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_cu.md
Name: mc_cu

Overview:
- Multi-cycle control unit for the MIPS-subset datapath. It sequences one shared ALU, one unified memory port and the register file across IF/ID/EXE/MEM/WB states, instead of decoding everything in a single cycle.
- Decodes the same instruction set as the single-cycle control unit: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal, plus the optional hamm.
- Adds a memory-ready handshake, illegal-instruction detection and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the instret counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-high
- op  in  6  opcode, from the datapath IR; stable after IF completes
- func  in  6  function field, from IR
- z  in  1  ALU zero flag, valid in EXE
- mem_ready  in  1  memory completes the current access this cycle
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU out
- wmem  out  1  memory write enable
- wreg  out  1  register file write enable
- regrt  out  1  destination register: 1 = rt, 0 = rd
- m2reg  out  1  write-back data: 1 = memory data, 0 = ALU result
- jal  out  1  write-back to $31 with PC+4
- shift  out  1  ALU A input = sa field
- sext  out  1  sign-extend immediate
- alusrca  out  1  ALU A source: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B source: 00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate<<2
- aluc  out  4  ALU operation code; same encoding as the single-cycle control unit
- pcsource  out  2  next-PC select: 00 = ALU, 01 = branch target register, 10 = register A, 11 = jump target
- state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
- illegal  out  1  one-cycle pulse in ID on an undecodable instruction
- instret  out  CNT_W  count of retired instructions

Behaviour:
- State register and instret are the only storage. All other outputs are combinational from state, op, func, z and mem_ready.
- While reset is high: state=IF, instret=0, and wpc, wir, wmem, wreg are forced to 0. Reset mid-instruction aborts it with no pending write.
- Any output not listed for a state is 0.

IF:
- iord=0, alusrca=0, alusrcb=01, aluc=add (x000), pcsource=00.
- wir=wpc=mem_ready.
- mem_ready=1 -> ID; otherwise hold IF with all outputs stable.

ID:
- Computes the branch target: alusrca=0, alusrcb=11, aluc=add, sext=1.
- j: wpc=1, pcsource=11 -> IF.
- jal: wpc=1, pcsource=11, wreg=1, jal=1 -> IF.
- jr: wpc=1, pcsource=10 -> IF.
- Undecodable op/func: illegal=1 -> IF, no write strobes.
- All other instructions -> EXE.

EXE:
- aluc and sext as in the single-cycle decode.
- alusrca=1, except shift instructions, which use shift=1.
- alusrcb: 00 for R-type/beq/bne, 10 for immediate, lw and sw.
- beq/bne: aluc=x100 (sub).
  - Taken (beq&z | bne&~z): wpc=1, pcsource=01.
  - Always -> IF.
- lw/sw -> MEM; all others -> WB.

MEM:
- iord=1; wmem=1 for sw, held until mem_ready.
- On mem_ready: sw -> IF, lw -> WB. Otherwise hold MEM.

WB:
- wreg=1; m2reg=1 for lw; regrt=1 for I-type -> IF.

instret:
- Increments by 1, wrapping modulo 2^CNT_W, on every transition into IF from a completing state:
  - ID for j/jal/jr
  - EXE for branches
  - MEM for sw
  - WB
- Does not increment on illegal instructions or when IF holds.

Boundary conditions:
- mem_ready held high continuously: lw takes 5 cycles, sw 4, R/I-type ALU 4, branch 3, jump 2.
- mem_ready low: IF or MEM stretches indefinitely; strobes stay asserted and unchanged.

Optional Feature:
- Macro: MC_CU_HAMM_EN.
- Defined: R-type func 110010 decodes as hamm.
  - Path is IF/ID/EXE/WB.
  - EXE: aluc=1011, alusrca=1, alusrcb=00.
  - WB: wreg=1, regrt=0.
  - Counts in instret.
- Undefined: func 110010 is illegal. It pulses illegal in ID, returns to IF, and instret is unchanged.

Test Plan:
- Reset, then mem_ready=1 with op=100011 (lw) -> state 0,1,2,3,4,0. WB has wreg=1, m2reg=1, regrt=1. instret 0->1.
- op=101011 (sw), mem_ready=0 for 3 cycles in MEM -> wmem=1 and iord=1 for 4 cycles, state stays 3, wreg never 1, then IF. instret +1.
- op=000100 (beq) with z=1 in EXE -> wpc=1, pcsource=01, back to IF at cycle 3. Repeat with z=0 -> wpc=0 in EXE.
- op=000011 (jal) -> ID has wpc=1, pcsource=11, wreg=1, jal=1, next state IF. op=111111 -> illegal=1 for one cycle, instret unchanged.
- lw with reset asserted while state=3 -> state=0, wmem=wreg=0, instret=0 immediately, without waiting for a clock edge.
- func=110010 with MC_CU_HAMM_EN -> EXE aluc=1011, WB wreg=1. Without the macro -> illegal=1 in ID.
